uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that sequences the MiniUart receive unit (rx_unit) and shares its received bytes with the CPU bus.
- Generates the 8x-oversample enable strobe from a programmable divisor.
- Drains each completed byte into a small FIFO and acknowledges the receiver with an over_read pulse.
- Exposes data, status, divisor and control registers plus an interrupt.
- Sits between rx_unit and the bus bridge inside the UART device.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64
DIV_W, 16, width of baud divisor and its counter
DIV_DEFAULT, 27, divisor after reset (en_rx period in clk cycles)
TIMEOUT_CHARS, 4, idle character times before timeout flag (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en_rx  out  1  oversample strobe to rx_unit, one clk wide
rx_data  in  8  rx_unit byte output
rx_rs  in  1  rx_unit byte-available status
over_read  out  1  acknowledge to rx_unit, registered one-clk pulse
addr  in  2  register select: 0 DATA, 1 STATUS, 2 DIVISOR, 3 CTRL
we  in  1  register write strobe
re  in  1  register read strobe
wdata  in  32  write data
rdata  out  32  read data, combinational on addr
irq  out  1  level interrupt

Behaviour:
- Reset (rst_n low, async): FIFO empty, overrun=0, timeout=0, divisor=DIV_DEFAULT, CTRL=0, capture FSM in IDLE. Outputs: en_rx=0, over_read=0, irq=0, rdata reflects reset register values.
- Divider:
  - DIV_W-bit down-counter; reloads divisor-1 on reaching 0, and en_rx pulses that cycle.
  - Divisor 0 or 1: en_rx high every cycle while enabled.
  - A DIVISOR write reloads the counter next cycle.
  - CTRL.en=0: en_rx held 0, counter held at reload value.
- Capture FSM: IDLE -> PUSH -> ACK -> WAIT_CLR -> IDLE.
  - IDLE: go to PUSH when rx_rs=1.
  - PUSH: write rx_data into FIFO if not full; if full, set overrun and drop the byte.
  - ACK: over_read=1 for exactly this cycle.
  - WAIT_CLR: return to IDLE when rx_rs=0.
  - Latency: rx_rs rise to FIFO count increment is 2 clk; to over_read is 2 clk.
  - FSM runs regardless of CTRL.en, so a pending byte is always drained.
- FIFO:
  - Read/write pointers carry one extra wrap bit; count = wptr - rptr, width log2(FIFO_DEPTH)+1.
  - Full when count==FIFO_DEPTH; empty when count==0.
  - Push and pop in the same cycle are both honoured; when full, the simultaneous pop makes room and no overrun is set.
- Register reads:
  - DATA: rdata[7:0] is the FIFO head, upper bits 0. re with FIFO non-empty pops one entry; re with FIFO empty returns 0 and does not pop.
  - STATUS: [0] avail (!empty), [1] full, [2] overrun, [3] timeout, [15:8] count. re on STATUS clears overrun and timeout; a set event in the same cycle wins.
  - DIVISOR: [DIV_W-1:0].
  - CTRL: [0] en, [1] ie.
- Register writes: DATA ignored; STATUS ignored; DIVISOR and CTRL written from wdata.
- irq = ie & (avail | overrun | timeout), registered one cycle.

Optional Feature:
UART_RX_TIMEOUT_EN.
- Defined:
  - Counter of en_rx pulses, cleared on every push, pop, or when FIFO is empty.
  - When it reaches TIMEOUT_CHARS*80 (10 bits x 8 samples) with FIFO non-empty, set sticky timeout.
  - The counter saturates.
- Undefined: no counter, STATUS[3] reads 0, irq ignores timeout.

Decomposition:
- Shared package uart_pkg: register address constants, STATUS/CTRL bit indices, capture FSM state encoding, the 10x8 sample-per-character constant.
- One sub-module is natural: uart_rx_fifo (parameterised sync FIFO with count, full, empty). The divider and FSM stay in uart_rx_ctrl.

Test Plan:
- Reset then read DIVISOR, STATUS, CTRL -> 27, 0, 0; en_rx and irq stay 0 for 100 cycles.
- CTRL=1, DIVISOR=4 -> en_rx pulses every 4 clk; write DIVISOR=1 -> en_rx high every cycle.
- rx_rs rises with rx_data=0xA5 -> over_read pulse 2 clk later; STATUS count=1; DATA read returns 0xA5, then count=0.
- Push 8 bytes without reads, then a 9th -> STATUS full=1 and overrun=1; 9th byte lost; STATUS read clears overrun; DATA reads return first 8 bytes in order.
- FIFO full, DATA read in the same cycle as PUSH -> count stays 8, overrun stays 0; ie=1 with data present -> irq=1.
- UART_RX_TIMEOUT_EN, DIVISOR=1, one byte pushed, no reads -> timeout and irq set after 320 en_rx pulses; DATA read clears the counter.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the MiniUart receive controller: register map,
// STATUS/CTRL bit positions, capture FSM encoding and sampling constants.
package uart_pkg;

   // Register select values on addr
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_DIVISOR = 2'd2;
   localparam logic [1:0] ADDR_CTRL    = 2'd3;

   // STATUS register bit positions (count occupies [15:8])
   localparam int STAT_AVAIL   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVERRUN = 2;
   localparam int STAT_TIMEOUT = 3;
   localparam int STAT_CNT_LSB = 8;

   // CTRL register bit positions
   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;

   // One character is 10 bit times, each sampled 8 times
   localparam int BITS_PER_CHAR    = 10;
   localparam int OVERSAMPLE       = 8;
   localparam int SAMPLES_PER_CHAR = BITS_PER_CHAR * OVERSAMPLE;

   // Capture FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PUSH     = 2'd1,
      ST_ACK      = 2'd2,
      ST_WAIT_CLR = 2'd3
   } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. Pointers carry an extra wrap bit so that the
// occupancy is a plain subtraction and full/empty need no extra state.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [CW-1:0] wptr_r;
   logic [CW-1:0] rptr_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign count     = wptr_r - rptr_r;
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == {CW{1'b0}});
   assign push_ok_s = push && (!full || pop);
   assign pop_ok_s  = pop && !empty;
   assign head      = mem_r[rptr_r[AW-1:0]];

   // Storage array: write the incoming byte at the write pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wptr_r[AW-1:0]] <= wdata;
      end
   end

   // Pointer update for accepted pushes and pops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r <= {CW{1'b0}};
         rptr_r <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wptr_r <= wptr_r + CW'(1);
         end
         if (pop_ok_s) begin
            rptr_r <= rptr_r + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// MiniUart receive controller: oversample divider, capture FSM that drains
// rx_unit into a FIFO, CPU register file and interrupt.
// Optional feature: define UART_RX_TIMEOUT_EN to add the idle-timeout flag.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter int DIV_W         = 16,
   parameter int DIV_DEFAULT   = 27,
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        en_rx,
   input  logic [7:0]  rx_data,
   input  logic        rx_rs,
   output logic        over_read,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DIV_W-1:0] DIV_RST       = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] DIV_RST_RELOAD = DIV_W'((DIV_DEFAULT > 1) ? DIV_DEFAULT - 1 : 0);

   logic [DIV_W-1:0] divisor_r;
   logic [DIV_W-1:0] div_cnt_r;
   logic [DIV_W-1:0] reload_s;
   logic             div_reload_r;
   logic             ctrl_en_r;
   logic             ctrl_ie_r;
   logic             en_rx_r;
   logic             over_read_r;
   logic             irq_r;
   logic             overrun_r;
   logic             timeout_s;
   cap_state_e       state_r;
   cap_state_e       state_nxt_s;
   logic             push_req_s;
   logic             ack_nxt_s;
   logic             pop_req_s;
   logic             overrun_set_s;
   logic             stat_clr_s;
   logic [7:0]       fifo_head_s;
   logic [CW-1:0]    fifo_count_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             unused_wdata_s;

   assign en_rx     = en_rx_r;
   assign over_read = over_read_r;
   assign irq       = irq_r;

   assign pop_req_s     = re && (addr == ADDR_DATA) && !fifo_empty_s;
   assign stat_clr_s    = re && (addr == ADDR_STATUS);
   // A pop in the same cycle frees a slot, so only a true loss is an overrun
   assign overrun_set_s = push_req_s && fifo_full_s && !pop_req_s;
   assign unused_wdata_s = &{1'b0, wdata[31:DIV_W]};

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req_s),
      .pop   (pop_req_s),
      .wdata (rx_data),
      .head  (fifo_head_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Reload value: divisors 0 and 1 both mean a strobe every cycle
   always_comb begin
      if (divisor_r <= DIV_W'(1)) begin
         reload_s = {DIV_W{1'b0}};
      end else begin
         reload_s = divisor_r - DIV_W'(1);
      end
   end

   // DIVISOR and CTRL registers, plus a one-cycle flag to reload the divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisor_r    <= DIV_RST;
         ctrl_en_r    <= 1'b0;
         ctrl_ie_r    <= 1'b0;
         div_reload_r <= 1'b0;
      end else begin
         div_reload_r <= we && (addr == ADDR_DIVISOR);
         if (we && (addr == ADDR_DIVISOR)) begin
            divisor_r <= wdata[DIV_W-1:0];
         end
         if (we && (addr == ADDR_CTRL)) begin
            ctrl_en_r <= wdata[CTRL_EN];
            ctrl_ie_r <= wdata[CTRL_IE];
         end
      end
   end

   // Oversample divider: down-counter, strobe on reaching zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= DIV_RST_RELOAD;
         en_rx_r   <= 1'b0;
      end else if (div_reload_r || !ctrl_en_r) begin
         div_cnt_r <= reload_s;
         en_rx_r   <= 1'b0;
      end else if (div_cnt_r == {DIV_W{1'b0}}) begin
         div_cnt_r <= reload_s;
         en_rx_r   <= 1'b1;
      end else begin
         div_cnt_r <= div_cnt_r - DIV_W'(1);
         en_rx_r   <= 1'b0;
      end
   end

   // Capture FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Capture FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:     state_nxt_s = rx_rs ? ST_PUSH : ST_IDLE;
         ST_PUSH:     state_nxt_s = ST_ACK;
         ST_ACK:      state_nxt_s = ST_WAIT_CLR;
         ST_WAIT_CLR: state_nxt_s = rx_rs ? ST_WAIT_CLR : ST_IDLE;
         default:     state_nxt_s = ST_IDLE;
      endcase
   end

   // Capture FSM outputs: push during PUSH, ack is registered into ACK
   always_comb begin
      push_req_s = 1'b0;
      ack_nxt_s  = 1'b0;
      case (state_r)
         ST_PUSH: begin
            push_req_s = 1'b1;
            ack_nxt_s  = 1'b1;
         end
         default: begin
            push_req_s = 1'b0;
            ack_nxt_s  = 1'b0;
         end
      endcase
   end

   // Registered acknowledge pulse to rx_unit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         over_read_r <= 1'b0;
      end else begin
         over_read_r <= ack_nxt_s;
      end
   end

   // Sticky overrun flag; a new overrun beats a STATUS-read clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_r <= 1'b0;
      end else if (overrun_set_s) begin
         overrun_r <= 1'b1;
      end else if (stat_clr_s) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TMO_LIMIT = TIMEOUT_CHARS * SAMPLES_PER_CHAR;
   localparam int TW        = $clog2(TMO_LIMIT + 1);

   logic [TW-1:0] tmo_cnt_r;
   logic          timeout_r;

   assign timeout_s = timeout_r;

   // Idle counter of en_rx strobes; any FIFO activity or emptiness restarts it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (push_req_s || pop_req_s || fifo_empty_s) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (en_rx_r && (tmo_cnt_r < TW'(TMO_LIMIT))) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // Sticky timeout flag; a new timeout beats a STATUS-read clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_r <= 1'b0;
      end else if ((tmo_cnt_r == TW'(TMO_LIMIT)) && !fifo_empty_s) begin
         timeout_r <= 1'b1;
      end else if (stat_clr_s) begin
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= timeout_r;
      end
   end
`else
   localparam int unused_timeout_chars = TIMEOUT_CHARS;
   assign timeout_s = 1'b0;
`endif

   // Level interrupt, registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= ctrl_ie_r && (!fifo_empty_s || overrun_r || timeout_s);
      end
   end

   // Register read mux, combinational on addr
   always_comb begin
      rdata = 32'h0000_0000;
      case (addr)
         ADDR_DATA: begin
            if (fifo_empty_s) begin
               rdata = 32'h0000_0000;
            end else begin
               rdata = {24'h00_0000, fifo_head_s};
            end
         end
         ADDR_STATUS: begin
            rdata[STAT_AVAIL]                   = !fifo_empty_s;
            rdata[STAT_FULL]                    = fifo_full_s;
            rdata[STAT_OVERRUN]                 = overrun_r;
            rdata[STAT_TIMEOUT]                 = timeout_s;
            rdata[STAT_CNT_LSB+7:STAT_CNT_LSB]  = 8'(fifo_count_s);
         end
         ADDR_DIVISOR: rdata = 32'(divisor_r);
         ADDR_CTRL:    rdata = {30'h0000_0000, ctrl_ie_r, ctrl_en_r};
         default:      rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl. Received bytes expected to
// land in the FIFO are queued when driven and compared when read back.
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_rx;
   logic [7:0]  rx_data;
   logic        rx_rs;
   logic        over_read;
   logic [1:0]  addr;
   logic        we;
   logic        re;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  sb_q[$];

   uart_rx_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_rx     (en_rx),
      .rx_data   (rx_data),
      .rx_rs     (rx_rs),
      .over_read (over_read),
      .addr      (addr),
      .we        (we),
      .re        (re),
      .wdata     (wdata),
      .rdata     (rdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Bound on total run time
   initial begin
      #2000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
      addr = a; re = 1'b1;
      #1 d = rdata;
      tick();
      re = 1'b0;
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1 d = rdata;
   endtask

   // Hand one byte over from the rx_unit side and wait for the acknowledge
   task automatic send_byte(input logic [7:0] b, input bit keep);
      int n;
      rx_data = b; rx_rs = 1'b1;
      n = 0;
      while (over_read !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("ack_seen", {31'd0, over_read}, 32'd1);
      rx_rs = 1'b0;
      tick();
      check("ack_one_cycle", {31'd0, over_read}, 32'd0);
      tick(); tick();
      if (keep) sb_q.push_back(b);
   endtask

   task automatic read_data_check(input string tag);
      logic [31:0] d;
      logic [7:0]  e;
      reg_rd(ADDR_DATA, d);
      if (sb_q.size() == 0) begin
         check(tag, d, 32'h0);
      end else begin
         e = sb_q.pop_front();
         check(tag, d, {24'h0, e});
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  e;
      int          seen;
      int          per;
      int          n;

      rst_n = 1'b0; rx_rs = 1'b0; rx_data = 8'h00;
      addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 32'h0;
      repeat (3) tick();
      check("rst_en_rx", {31'd0, en_rx}, 32'd0);
      check("rst_over_read", {31'd0, over_read}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Reset register values
      reg_rd(ADDR_DIVISOR, d); check("rst_divisor", d, 32'd27);
      reg_rd(ADDR_STATUS, d);  check("rst_status", d, 32'h0);
      reg_rd(ADDR_CTRL, d);    check("rst_ctrl", d, 32'h0);
      peek(ADDR_DATA, d);      check("rst_data", d, 32'h0);
      seen = 0;
      repeat (100) begin
         tick();
         if (en_rx === 1'b1 || irq === 1'b1) seen++;
      end
      check("idle_quiet", seen, 32'd0);

      // Divider: period 4, then every cycle
      reg_wr(ADDR_CTRL, 32'h1);
      reg_wr(ADDR_DIVISOR, 32'd4);
      n = 0;
      while (en_rx !== 1'b1 && n < 20) begin tick(); n++; end
      check("en_rx_found", {31'd0, en_rx}, 32'd1);
      tick();
      check("en_rx_width", {31'd0, en_rx}, 32'd0);
      per = 1;
      while (en_rx !== 1'b1 && per < 20) begin tick(); per++; end
      check("en_rx_period4", per, 32'd4);
      reg_wr(ADDR_DIVISOR, 32'd1);
      tick(); tick();
      seen = 0;
      repeat (6) begin
         if (en_rx === 1'b1) seen++;
         tick();
      end
      check("en_rx_div1", seen, 32'd6);
      reg_wr(ADDR_CTRL, 32'h0);
      tick(); tick();
      check("en_rx_disabled", {31'd0, en_rx}, 32'd0);

      // Single byte with exact latency
      rx_data = 8'hA5; rx_rs = 1'b1;
      tick();
      check("a5_ack_early", {31'd0, over_read}, 32'd0);
      peek(ADDR_STATUS, d); check("a5_cnt_early", d, 32'h0);
      tick();
      check("a5_ack_2clk", {31'd0, over_read}, 32'd1);
      peek(ADDR_STATUS, d); check("a5_status", d, 32'h0000_0101);
      tick();
      check("a5_ack_width", {31'd0, over_read}, 32'd0);
      rx_rs = 1'b0;
      tick(); tick();
      sb_q.push_back(8'hA5);
      read_data_check("a5_data");
      reg_rd(ADDR_STATUS, d); check("a5_status_after", d, 32'h0);

      // Fill, overflow, clear, drain in order
      for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i * 7), 1'b1);
      send_byte(8'hEE, 1'b0);
      reg_rd(ADDR_STATUS, d); check("ovr_status", d, 32'h0000_0807);
      reg_rd(ADDR_STATUS, d); check("ovr_cleared", d, 32'h0000_0803);
      for (int i = 0; i < 8; i++) read_data_check("ovr_drain");
      reg_rd(ADDR_STATUS, d); check("ovr_empty", d, 32'h0);

      // DATA write ignored, empty DATA read returns 0 without popping
      reg_wr(ADDR_DATA, 32'hFF);
      reg_rd(ADDR_STATUS, d); check("data_wr_ignored", d, 32'h0);
      read_data_check("empty_read");
      reg_rd(ADDR_STATUS, d); check("empty_no_pop", d, 32'h0);

      // Full FIFO with a pop in the PUSH cycle
      for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i), 1'b1);
      rx_data = 8'h5C; rx_rs = 1'b1;
      tick();
      addr = ADDR_DATA; re = 1'b1;
      #1 d = rdata;
      tick();
      re = 1'b0;
      e = sb_q.pop_front();
      check("fullpop_data", d, {24'h0, e});
      sb_q.push_back(8'h5C);
      rx_rs = 1'b0;
      tick(); tick(); tick();
      reg_rd(ADDR_STATUS, d); check("fullpop_status", d, 32'h0000_0803);
      reg_wr(ADDR_CTRL, 32'h2);
      tick(); tick();
      check("irq_avail", {31'd0, irq}, 32'd1);
      reg_rd(ADDR_CTRL, d); check("ctrl_ie", d, 32'h2);
      for (int i = 0; i < 8; i++) read_data_check("fullpop_drain");
      tick(); tick();
      check("irq_clear", {31'd0, irq}, 32'd0);

`ifdef UART_RX_TIMEOUT_EN
      // Timeout after 320 strobes with a byte sitting in the FIFO
      reg_wr(ADDR_DIVISOR, 32'd1);
      reg_wr(ADDR_CTRL, 32'h3);
      send_byte(8'hC3, 1'b1);
      repeat (290) tick();
      peek(ADDR_STATUS, d); check("tmo_not_yet", d, 32'h0000_0101);
      repeat (40) tick();
      peek(ADDR_STATUS, d); check("tmo_set", d, 32'h0000_0109);
      check("tmo_irq", {31'd0, irq}, 32'd1);
      read_data_check("tmo_data");
      peek(ADDR_STATUS, d); check("tmo_sticky", d, 32'h0000_0008);
      reg_rd(ADDR_STATUS, d);
      peek(ADDR_STATUS, d); check("tmo_clr", d, 32'h0);
      send_byte(8'h3C, 1'b1);
      repeat (300) tick();
      peek(ADDR_STATUS, d); check("tmo_restart", d, 32'h0000_0101);
      read_data_check("tmo_data2");
`else
      // Without the timeout feature STATUS[3] never sets
      reg_wr(ADDR_DIVISOR, 32'd1);
      reg_wr(ADDR_CTRL, 32'h1);
      send_byte(8'hC3, 1'b1);
      repeat (400) tick();
      peek(ADDR_STATUS, d); check("no_tmo", d, 32'h0000_0101);
      read_data_check("no_tmo_data");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
